ift_mem_bridge: RTL and testbench

IFT_MEM_BRIDGE -- requirements
Module: ift_mem_bridge

---
 rtl/ift_mem_bridge.sv | 193 +++++++++++++++++++
 tb/tb_ift_mem_bridge.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ift_mem_bridge.sv
// SRAM/MMIO bridge with per-byte taint tracking. The taint array is cleared word by
// word after reset. Read responses come back through a ReadLatency-deep pipeline.
module ift_mem_bridge #(
  parameter int unsigned          NumWords    = 1 << 20,
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 64,
  parameter int unsigned          StrbWidth   = DataWidth / 8,
  parameter logic [AddrWidth-1:0] MemBase     = 32'h8000_0000,
  parameter int unsigned          ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 ready_o,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [StrbWidth-1:0] strb_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  input  logic                 req_i_t0,
  input  logic                 we_i_t0,
  input  logic [AddrWidth-1:0] addr_i_t0,
  input  logic [DataWidth-1:0] wdata_i_t0,
  input  logic [StrbWidth-1:0] strb_i_t0,
  output logic [DataWidth-1:0] rdata_o_t0,
  output logic                 mmio_req_o,
  output logic                 mmio_we_o,
  output logic [AddrWidth-1:0] mmio_addr_o,
  output logic [DataWidth-1:0] mmio_wdata_o,
  output logic [StrbWidth-1:0] mmio_strb_o,
  input  logic [DataWidth-1:0] mmio_rdata_i,
  output logic                 mmio_req_o_t0,
  output logic                 mmio_we_o_t0,
  output logic [AddrWidth-1:0] mmio_addr_o_t0,
  output logic [DataWidth-1:0] mmio_wdata_o_t0,
  output logic [StrbWidth-1:0] mmio_strb_o_t0,
  input  logic [DataWidth-1:0] mmio_rdata_i_t0,
  output logic [31:0]          tainted_writes_o,
  output logic                 oob_o
);

  localparam int unsigned OffW       = $clog2(StrbWidth);
  localparam int unsigned IdxW       = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [63:0] RangeBytes = 64'(NumWords) * 64'(StrbWidth);

  typedef enum logic [0:0] {CLEAR, RUN} state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e               state, state_nx;
  logic [IdxW-1:0]      clr_idx;
  logic                 accept, hit, ctrl_taint, fwd, wr_hit, rd_hit;
  logic [AddrWidth-1:0] offset;
  logic [IdxW-1:0]      idx;
  logic [31:0]          cnt;
  logic                 oob;

  logic [DataWidth-1:0] mem  [NumWords];
  logic [DataWidth-1:0] tmem [NumWords];

  logic                 vld_p0;
  logic                 mmio_p0, ctl_p0;
  logic [DataWidth-1:0] rd_p0, rt_p0;
  logic [DataWidth-1:0] s0_dat, s0_tnt;
  logic                 out_vld;
  logic [DataWidth-1:0] out_dat, out_tnt;

  // Request decode (acceptance cycle)
  assign ready_o    = (state == RUN);
  assign accept     = req_i & ready_o;
  assign offset     = addr_i - MemBase;
  assign hit        = (addr_i >= MemBase) && (64'(offset) < RangeBytes);
  assign idx        = offset[OffW +: IdxW];
  assign ctrl_taint = req_i_t0 | we_i_t0 | (|addr_i_t0) | (|strb_i_t0);
  assign fwd        = accept & ~hit;
  assign wr_hit     = accept & hit & we_i;
  assign rd_hit     = accept & hit & ~we_i;

  assign mmio_req_o      = fwd;
  assign mmio_we_o       = fwd & we_i;
  assign mmio_addr_o     = fwd ? addr_i : '0;
  assign mmio_wdata_o    = fwd ? wdata_i : '0;
  assign mmio_strb_o     = fwd ? strb_i : '0;
  assign mmio_req_o_t0   = fwd & req_i_t0;
  assign mmio_we_o_t0    = fwd & we_i_t0;
  assign mmio_addr_o_t0  = fwd ? addr_i_t0 : '0;
  assign mmio_wdata_o_t0 = fwd ? wdata_i_t0 : '0;
  assign mmio_strb_o_t0  = fwd ? strb_i_t0 : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= CLEAR;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_idx == IdxW'(NumWords - 1)) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              clr_idx <= '0;
    else if (state == CLEAR)  clr_idx <= clr_idx + IdxW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      oob <= 1'b0;
    end else begin
      if (accept && ctrl_taint) cnt <= sat_inc(cnt);
      if (req_i && !ready_o)    oob <= 1'b1;
    end
  end

  assign tainted_writes_o = cnt;
  assign oob_o            = oob;

  // Array access: nonblocking reads see contents from before this edge's writes
  always_ff @(posedge clk_i) begin
    if (state == CLEAR) begin
      tmem[clr_idx] <= '0;
    end else if (wr_hit) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (strb_i[b]) begin
          mem[idx][8*b +: 8]  <= wdata_i[8*b +: 8];
          tmem[idx][8*b +: 8] <= ctrl_taint ? 8'hFF : wdata_i_t0[8*b +: 8];
        end
      end
    end
    if (rd_hit) begin
      rd_p0 <= mem[idx];
      rt_p0 <= tmem[idx];
    end
    mmio_p0 <= ~hit;
    ctl_p0  <= ctrl_taint;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_p0 <= 1'b0;
    else         vld_p0 <= accept & ~we_i;
  end

  // Stage 0: MMIO read data is sampled here, one cycle after acceptance
  assign s0_dat = mmio_p0 ? mmio_rdata_i : rd_p0;
  assign s0_tnt = ctl_p0 ? '1 : (mmio_p0 ? mmio_rdata_i_t0 : rt_p0);

  generate
    if (ReadLatency == 1) begin : g_direct
      assign out_vld = vld_p0;
      assign out_dat = s0_dat;
      assign out_tnt = s0_tnt;
    end else begin : g_delay
      logic [ReadLatency-2:0] vld_pk;
      logic [DataWidth-1:0]   dat_pk [ReadLatency-1];
      logic [DataWidth-1:0]   tnt_pk [ReadLatency-1];

      // Stages 1..ReadLatency-1
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vld_pk <= '0;
        end else begin
          vld_pk[0] <= vld_p0;
          for (int k = 1; k < ReadLatency - 1; k++) vld_pk[k] <= vld_pk[k-1];
        end
      end

      always_ff @(posedge clk_i) begin
        dat_pk[0] <= s0_dat;
        tnt_pk[0] <= s0_tnt;
        for (int k = 1; k < ReadLatency - 1; k++) begin
          dat_pk[k] <= dat_pk[k-1];
          tnt_pk[k] <= tnt_pk[k-1];
        end
      end

      assign out_vld = vld_pk[ReadLatency-2];
      assign out_dat = dat_pk[ReadLatency-2];
      assign out_tnt = tnt_pk[ReadLatency-2];
    end
  endgenerate

  assign rvalid_o   = out_vld;
  assign rdata_o    = out_vld ? out_dat : '0;
  assign rdata_o_t0 = out_vld ? out_tnt : '0;

endmodule

// File: tb/tb_ift_mem_bridge.sv
// Bench for ift_mem_bridge (16 words, 64-bit data, two-cycle reads), compared against
// an array/queue model of the memory, taint array, tainted-request counter and response order.
module tb_ift_mem_bridge;
  localparam int          NW   = 16;
  localparam int          AW   = 32;
  localparam int          DW   = 64;
  localparam int          SW   = 8;
  localparam int          RL   = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic          clk, rst_ni;
  logic          ready_o, req_i, we_i, rvalid_o;
  logic [AW-1:0] addr_i, addr_i_t0, mmio_addr_o, mmio_addr_o_t0;
  logic [DW-1:0] wdata_i, wdata_i_t0, rdata_o, rdata_o_t0;
  logic [SW-1:0] strb_i, strb_i_t0, mmio_strb_o, mmio_strb_o_t0;
  logic          req_i_t0, we_i_t0;
  logic          mmio_req_o, mmio_we_o, mmio_req_o_t0, mmio_we_o_t0;
  logic [DW-1:0] mmio_wdata_o, mmio_wdata_o_t0, mmio_rdata_i, mmio_rdata_i_t0;
  logic [31:0]   tainted_writes_o;
  logic          oob_o;

  ift_mem_bridge #(.NumWords(NW), .AddrWidth(AW), .DataWidth(DW), .MemBase(BASE),
                   .ReadLatency(RL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ready_o(ready_o), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .strb_i(strb_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .req_i_t0(req_i_t0), .we_i_t0(we_i_t0), .addr_i_t0(addr_i_t0),
    .wdata_i_t0(wdata_i_t0), .strb_i_t0(strb_i_t0), .rdata_o_t0(rdata_o_t0),
    .mmio_req_o(mmio_req_o), .mmio_we_o(mmio_we_o), .mmio_addr_o(mmio_addr_o),
    .mmio_wdata_o(mmio_wdata_o), .mmio_strb_o(mmio_strb_o), .mmio_rdata_i(mmio_rdata_i),
    .mmio_req_o_t0(mmio_req_o_t0), .mmio_we_o_t0(mmio_we_o_t0),
    .mmio_addr_o_t0(mmio_addr_o_t0), .mmio_wdata_o_t0(mmio_wdata_o_t0),
    .mmio_strb_o_t0(mmio_strb_o_t0), .mmio_rdata_i_t0(mmio_rdata_i_t0),
    .tainted_writes_o(tainted_writes_o), .oob_o(oob_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [63:0] mem_m [NW];
  logic [63:0] tnt_m [NW];
  logic [31:0] cnt_m;
  logic [63:0] mmh_d [64];
  logic [63:0] mmh_t [64];

  typedef struct {
    int          due;
    int          iss;
    bit          mm;
    bit          ctl;
    logic [63:0] d;
    logic [63:0] t;
  } resp_t;
  resp_t q[$];

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; strb_i = '0;
    req_i_t0 = 0; we_i_t0 = 0; addr_i_t0 = '0; wdata_i_t0 = '0; strb_i_t0 = '0;
  endtask

  // Drive one request and apply it to the model; returns the read expectation.
  task automatic issue(input logic we, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] s, input logic rt, input logic wt,
                       input logic [31:0] at, input logic [63:0] dt, input logic [7:0] st,
                       output logic [63:0] ed, output logic [63:0] et,
                       output bit h, output bit c);
    int w;
    req_i = 1; we_i = we; addr_i = a; wdata_i = d; strb_i = s;
    req_i_t0 = rt; we_i_t0 = wt; addr_i_t0 = at; wdata_i_t0 = dt; strb_i_t0 = st;
    h  = (a >= BASE) && (a < BASE + NW * SW);
    c  = rt | wt | (|at) | (|st);
    ed = '0;
    et = '0;
    if (c) cnt_m = (cnt_m == 32'hFFFF_FFFF) ? cnt_m : cnt_m + 1;
    if (h) begin
      w  = int'((a - BASE) / SW);
      ed = mem_m[w];
      et = tnt_m[w];
      if (we) begin
        for (int b = 0; b < SW; b++) begin
          if (s[b]) begin
            mem_m[w][8*b +: 8] = d[8*b +: 8];
            tnt_m[w][8*b +: 8] = c ? 8'hFF : dt[8*b +: 8];
          end
        end
      end
    end
    if (c) et = '1;
  endtask

  // Waits (bounded) for the next response after a read was just driven.
  task automatic collect(output int lat, output logic [63:0] d, output logic [63:0] t);
    lat = 0; d = '0; t = '0;
    for (int k = 1; k <= 6; k++) begin
      next_cyc();
      if (k == 1) idle();
      if (rvalid_o === 1'b1) begin
        lat = k; d = rdata_o; t = rdata_o_t0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int low;
    bit saw_rv;
    rst_ni = 0;
    idle();
    req_i = 1; addr_i = 32'h1000_0000; addr_i_t0 = 32'hFF;
    repeat (3) next_cyc();
    tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready_o); end
    tests++; if (rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b want 0", rvalid_o); end
    tests++; if (oob_o !== 1'b0) begin fails++; $display("FAIL reset_oob got %b want 0", oob_o); end
    tests++; if (tainted_writes_o !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", tainted_writes_o); end
    tests++; if (mmio_req_o !== 1'b0 || mmio_addr_o_t0 !== '0) begin
      fails++; $display("FAIL reset_mmio got req=%b t0=%h want 0/0", mmio_req_o, mmio_addr_o_t0);
    end
    idle();
    rst_ni = 1;
    low = (ready_o === 1'b0) ? 1 : 0;
    saw_rv = 0;
    for (int i = 1; i <= 40; i++) begin
      next_cyc();
      if (rvalid_o === 1'b1) saw_rv = 1;
      if (i == 4) idle();
      if (ready_o === 1'b1) break;
      low++;
      if (i == 3) begin
        req_i = 1; addr_i = 32'h1000_0000;
        #1;
        tests++; if (mmio_req_o !== 1'b0) begin fails++; $display("FAIL clear_drop_mmio got %b want 0", mmio_req_o); end
      end
    end
    tests++; if (low != NW) begin fails++; $display("FAIL clear_len got %0d want %0d", low, NW); end
    repeat (3) begin next_cyc(); if (rvalid_o === 1'b1) saw_rv = 1; end
    tests++; if (oob_o !== 1'b1) begin fails++; $display("FAIL clear_oob got %b want 1", oob_o); end
    tests++; if (saw_rv !== 1'b0) begin fails++; $display("FAIL clear_no_resp got %b want 0", saw_rv); end
    cnt_m = 0;
    for (int w = 0; w < NW; w++) tnt_m[w] = '0;
  endtask

  task automatic init_words();
    logic [63:0] ed, et;
    bit h, c;
    for (int w = 0; w < NW; w++) begin
      next_cyc();
      issue(1, BASE + 32'(w * SW), {$urandom, $urandom}, 8'hFF, 0, 0, '0, '0, '0, ed, et, h, c);
    end
    next_cyc();
    idle();
  endtask

  task automatic test_round_trip();
    logic [63:0] ed, et, d, t;
    bit h, c;
    int lat;
    next_cyc();
    issue(1, 32'h8000_0008, 64'h1122334455667788, 8'hFF, 0, 0, '0, '0, '0, ed, et, h, c);
    next_cyc();
    issue(0, 32'h8000_0008, '0, 8'h00, 0, 0, '0, '0, '0, ed, et, h, c);
    collect(lat, d, t);
    tests++; if (lat != RL) begin fails++; $display("FAIL rt_latency got %0d want %0d", lat, RL); end
    tests++; if (d !== 64'h1122334455667788) begin fails++; $display("FAIL rt_data got %h want 1122334455667788", d); end
    tests++; if (t !== 64'h0) begin fails++; $display("FAIL rt_taint got %h want 0", t); end
    next_cyc();
    tests++; if (rvalid_o !== 1'b0 || rdata_o !== '0 || rdata_o_t0 !== '0) begin
      fails++; $display("FAIL rt_idle_zero got v=%b d=%h t=%h want 0", rvalid_o, rdata_o, rdata_o_t0);
    end
  endtask

  task automatic test_partial_taint();
    logic [63:0] ed, et, d, t;
    bit h, c;
    int lat;
    next_cyc();
    issue(1, 32'h8000_0008, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 0, 0, '0, 64'hFF, '0, ed, et, h, c);
    next_cyc();
    issue(0, 32'h8000_0008, '0, 8'h00, 0, 0, '0, '0, '0, ed, et, h, c);
    collect(lat, d, t);
    tests++; if (d !== 64'h1122_3344_CCCC_DDDD) begin fails++; $display("FAIL pt_data got %h want 11223344ccccdddd", d); end
    tests++; if (t !== 64'h0000_0000_0000_00FF) begin fails++; $display("FAIL pt_taint got %h want 00000000000000ff", t); end
    next_cyc();
    issue(1, 32'h8000_0008, 64'h0102_0304_0506_0708, 8'h0F, 0, 0, 32'h1, '0, '0, ed, et, h, c);
    next_cyc();
    idle();
    tests++; if (tainted_writes_o !== 32'd1) begin fails++; $display("FAIL pt_count got %0d want 1", tainted_writes_o); end
    next_cyc();
    issue(0, 32'h8000_0008, '0, 8'h00, 0, 0, '0, '0, '0, ed, et, h, c);
    collect(lat, d, t);
    tests++; if (d !== 64'h1122_3344_0506_0708) begin fails++; $display("FAIL pt_ctl_data got %h want 1122334405060708", d); end
    tests++; if (t !== 64'h0000_0000_FFFF_FFFF) begin fails++; $display("FAIL pt_ctl_taint got %h want 00000000ffffffff", t); end
  endtask

  task automatic test_mmio();
    logic [63:0] ed, et, d, t, ea, ec;
    bit h, c;
    int lat;
    mmio_rdata_i = 64'hDEAD; mmio_rdata_i_t0 = '0;
    next_cyc();
    issue(0, 32'h1000_0000, '0, 8'h00, 0, 0, '0, '0, '0, ed, et, h, c);
    #1;
    tests++; if (mmio_req_o !== 1'b1 || mmio_addr_o !== 32'h1000_0000 || mmio_we_o !== 1'b0) begin
      fails++; $display("FAIL mmio_fwd got req=%b addr=%h we=%b want 1/10000000/0", mmio_req_o, mmio_addr_o, mmio_we_o);
    end
    collect(lat, d, t);
    tests++; if (lat != RL || d !== 64'hDEAD) begin fails++; $display("FAIL mmio_read got lat=%0d d=%h want %0d/dead", lat, d, RL); end
    mmio_rdata_i = 64'hBEEF;
    next_cyc();
    issue(0, 32'h8000_0010, '0, 8'h00, 0, 0, '0, '0, '0, ea, et, h, c);
    next_cyc();
    issue(0, 32'h2000_0000, '0, 8'h00, 0, 0, '0, '0, '0, ed, et, h, c);
    next_cyc();
    issue(0, 32'h8000_0008, '0, 8'h00, 0, 0, '0, '0, '0, ec, et, h, c);
    tests++; if (rvalid_o !== 1'b1 || rdata_o !== ea) begin fails++; $display("FAIL b2b_first got v=%b d=%h want 1/%h", rvalid_o, rdata_o, ea); end
    next_cyc();
    idle();
    tests++; if (rvalid_o !== 1'b1 || rdata_o !== 64'hBEEF) begin fails++; $display("FAIL b2b_mmio got v=%b d=%h want 1/beef", rvalid_o, rdata_o); end
    next_cyc();
    tests++; if (rvalid_o !== 1'b1 || rdata_o !== ec) begin fails++; $display("FAIL b2b_third got v=%b d=%h want 1/%h", rvalid_o, rdata_o, ec); end
    next_cyc();
    tests++; if (rvalid_o !== 1'b0) begin fails++; $display("FAIL b2b_end got %b want 0", rvalid_o); end
  endtask

  task automatic test_boundary();
    logic [63:0] ed, et, d, t, w0;
    bit h, c;
    int lat;
    w0 = mem_m[0];
    next_cyc();
    issue(1, 32'h8000_0078, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 0, '0, '0, '0, ed, et, h, c);
    #1;
    tests++; if (mmio_req_o !== 1'b0) begin fails++; $display("FAIL bnd_last_mmio got %b want 0", mmio_req_o); end
    next_cyc();
    issue(1, 32'h8000_0080, 64'h5555_6666_7777_8888, 8'hFF, 0, 0, '0, '0, '0, ed, et, h, c);
    #1;
    tests++; if (mmio_req_o !== 1'b1 || mmio_we_o !== 1'b1 || mmio_wdata_o !== 64'h5555_6666_7777_8888) begin
      fails++; $display("FAIL bnd_past_mmio got req=%b we=%b d=%h want 1/1/5555666677778888", mmio_req_o, mmio_we_o, mmio_wdata_o);
    end
    next_cyc();
    issue(0, 32'h8000_007F, '0, 8'h00, 0, 0, '0, '0, '0, ed, et, h, c);
    collect(lat, d, t);
    tests++; if (d !== 64'hCAFE_F00D_1234_5678) begin fails++; $display("FAIL bnd_last_data got %h want cafef00d12345678", d); end
    next_cyc();
    issue(0, 32'h8000_0000, '0, 8'h00, 0, 0, '0, '0, '0, ed, et, h, c);
    collect(lat, d, t);
    tests++; if (d !== w0) begin fails++; $display("FAIL bnd_word0 got %h want %h", d, w0); end
  endtask

  task automatic test_random();
    localparam int N = 400;
    logic [63:0] ed, et, xd, xt, d, dt;
    logic [31:0] a, at;
    logic [7:0]  s, st;
    logic        we, rt, wt;
    bit h, c;
    resp_t e;
    for (int step = 0; step < N; step++) begin
      next_cyc();
      if (q.size() > 0 && q[0].due == cyc) begin
        e  = q.pop_front();
        xd = e.mm ? mmh_d[(e.iss + 1) & 63] : e.d;
        xt = e.ctl ? '1 : (e.mm ? mmh_t[(e.iss + 1) & 63] : e.t);
        tests++; if (rvalid_o !== 1'b1 || rdata_o !== xd || rdata_o_t0 !== xt) begin
          fails++; $display("FAIL rnd_resp cyc=%0d got v=%b d=%h t=%h want 1/%h/%h", cyc, rvalid_o, rdata_o, rdata_o_t0, xd, xt);
        end
      end else begin
        tests++; if (rvalid_o !== 1'b0 || rdata_o !== '0 || rdata_o_t0 !== '0) begin
          fails++; $display("FAIL rnd_idle cyc=%0d got v=%b d=%h t=%h want 0/0/0", cyc, rvalid_o, rdata_o, rdata_o_t0);
        end
      end
      tests++; if (tainted_writes_o !== cnt_m) begin fails++; $display("FAIL rnd_count got %0d want %0d", tainted_writes_o, cnt_m); end
      mmio_rdata_i = {$urandom, $urandom};
      mmio_rdata_i_t0 = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : '0;
      mmh_d[cyc & 63] = mmio_rdata_i;
      mmh_t[cyc & 63] = mmio_rdata_i_t0;
      if (step < N - 4 && $urandom_range(0, 9) != 0) begin
        we = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       a = {1'b0, 31'($urandom)};
          1:       a = BASE + 32'h80 + 32'($urandom_range(0, 255));
          default: a = BASE + 32'($urandom_range(0, NW * SW - 1));
        endcase
        d = {$urandom, $urandom};
        s = 8'($urandom);
        rt = 0; wt = 0; at = '0; st = '0;
        if ($urandom_range(0, 4) == 0) begin
          case ($urandom_range(0, 3))
            0:       rt = 1;
            1:       wt = 1;
            2:       at = 32'(1) << $urandom_range(0, 31);
            default: st = 8'(1) << $urandom_range(0, 7);
          endcase
        end
        dt = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : '0;
        issue(we, a, d, s, rt, wt, at, dt, st, ed, et, h, c);
        if (!we) begin
          e.due = cyc + RL; e.iss = cyc; e.mm = !h; e.ctl = c; e.d = ed; e.t = et;
          q.push_back(e);
        end
        #1;
        tests++; if (mmio_req_o !== !h || mmio_addr_o_t0 !== (h ? 32'h0 : at)) begin
          fails++; $display("FAIL rnd_mmio a=%h got req=%b t0=%h want %b/%h", a, mmio_req_o, mmio_addr_o_t0, !h, h ? 32'h0 : at);
        end
      end else begin
        idle();
      end
    end
    tests++; if (q.size() != 0) begin fails++; $display("FAIL rnd_drain got %0d pending want 0", q.size()); end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] ed, et, d, t;
    bit h, c, saw_rv;
    int low, lat;
    mmio_rdata_i_t0 = '0;
    next_cyc();
    issue(0, 32'h8000_0018, '0, 8'h00, 1, 0, '0, '0, '0, ed, et, h, c);
    next_cyc();
    issue(0, 32'h8000_0020, '0, 8'h00, 1, 0, '0, '0, '0, ed, et, h, c);
    next_cyc();
    idle();
    tests++; if (tainted_writes_o !== cnt_m) begin fails++; $display("FAIL mf_pre_count got %0d want %0d", tainted_writes_o, cnt_m); end
    rst_ni = 0;
    #1;
    tests++; if (rvalid_o !== 1'b0 || rdata_o_t0 !== '0 || tainted_writes_o !== 32'd0 || ready_o !== 1'b0) begin
      fails++; $display("FAIL mf_reset got v=%b t=%h cnt=%0d rdy=%b want 0/0/0/0", rvalid_o, rdata_o_t0, tainted_writes_o, ready_o);
    end
    saw_rv = 0;
    repeat (3) begin next_cyc(); if (rvalid_o === 1'b1) saw_rv = 1; end
    rst_ni = 1;
    low = 1;
    for (int i = 1; i <= 40; i++) begin
      next_cyc();
      if (rvalid_o === 1'b1) saw_rv = 1;
      if (ready_o === 1'b1) break;
      low++;
    end
    tests++; if (saw_rv !== 1'b0) begin fails++; $display("FAIL mf_no_resp got %b want 0", saw_rv); end
    tests++; if (low != NW) begin fails++; $display("FAIL mf_clear_len got %0d want %0d", low, NW); end
    next_cyc();
    issue(0, 32'h8000_0008, '0, 8'h00, 0, 0, '0, '0, '0, ed, et, h, c);
    collect(lat, d, t);
    tests++; if (lat != RL || t !== '0) begin fails++; $display("FAIL mf_taint_cleared got lat=%0d t=%h want %0d/0", lat, t, RL); end
  endtask

  initial begin
    rst_ni = 0;
    idle();
    mmio_rdata_i = '0;
    mmio_rdata_i_t0 = '0;
    cnt_m = 0;
    test_reset();
    init_words();
    test_round_trip();
    test_partial_taint();
    test_mmio();
    test_boundary();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
